// File: rtl/hash_batch_bus_arbiter_if.sv
// Hash batch bus arbiter interface.
// Bundles the per-source hash-batch inputs (flattened, source k in slice k),
// the single bus-head output beat and the grant status.
//   master : environment side, which drives source beats and bus-head o_ready
//   slave  : arbiter side, which drives i_ready, the bus-head beat and the grant status
// Payload fields per beat: head_addr, history_valid, history_addr,
// meta_match_len, meta_match_can_ext, delim.
interface hash_batch_bus_arbiter_if #(
    parameter int unsigned NUM_SRC              = 4,
    parameter int unsigned SRC_IDX_W            = $clog2(NUM_SRC),
    parameter int unsigned ADDR_WIDTH           = 16,
    parameter int unsigned HASH_ISSUE_WIDTH     = 4,
    parameter int unsigned META_MATCH_LEN_WIDTH = 5
);
    localparam int unsigned HIST_ADDR_W = HASH_ISSUE_WIDTH * ADDR_WIDTH;
    localparam int unsigned MML_W       = HASH_ISSUE_WIDTH * META_MATCH_LEN_WIDTH;

    // Source side
    logic [NUM_SRC-1:0]                  i_valid;
    logic [NUM_SRC*ADDR_WIDTH-1:0]       i_head_addr;
    logic [NUM_SRC*HASH_ISSUE_WIDTH-1:0] i_history_valid;
    logic [NUM_SRC*HIST_ADDR_W-1:0]      i_history_addr;
    logic [NUM_SRC*MML_W-1:0]            i_meta_match_len;
    logic [NUM_SRC*HASH_ISSUE_WIDTH-1:0] i_meta_match_can_ext;
    logic [NUM_SRC-1:0]                  i_delim;
    logic [NUM_SRC-1:0]                  i_ready;

    // Bus-head side
    logic                                o_valid;
    logic [ADDR_WIDTH-1:0]               o_head_addr;
    logic [HASH_ISSUE_WIDTH-1:0]         o_history_valid;
    logic [HIST_ADDR_W-1:0]              o_history_addr;
    logic [MML_W-1:0]                    o_meta_match_len;
    logic [HASH_ISSUE_WIDTH-1:0]         o_meta_match_can_ext;
    logic                                o_delim;
    logic                                o_ready;

    // Grant status
    logic                                o_locked;
    logic [SRC_IDX_W-1:0]                o_grant_idx;

    modport master (
        output i_valid, i_head_addr, i_history_valid, i_history_addr,
               i_meta_match_len, i_meta_match_can_ext, i_delim, o_ready,
        input  i_ready, o_valid, o_head_addr, o_history_valid, o_history_addr,
               o_meta_match_len, o_meta_match_can_ext, o_delim, o_locked, o_grant_idx
    );

    modport slave (
        input  i_valid, i_head_addr, i_history_valid, i_history_addr,
               i_meta_match_len, i_meta_match_can_ext, i_delim, o_ready,
        output i_ready, o_valid, o_head_addr, o_history_valid, o_history_addr,
               o_meta_match_len, o_meta_match_can_ext, o_delim, o_locked, o_grant_idx
    );
endinterface

// File: rtl/hash_batch_bus_arbiter.sv
// Hash batch bus arbiter.
// Merges NUM_SRC hash-batch streams onto the head of the hash batch bus.
// Round-robin arbitration at packet granularity: a granted source keeps the
// grant until its delim beat is accepted. A 2-entry registered FIFO sits
// between the arbitration mux and the bus head.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave modport of hash_batch_bus_arbiter_if (source beats, i_ready,
//          bus-head beat with o_valid/o_ready, o_locked, o_grant_idx)
module hash_batch_bus_arbiter #(
    parameter int unsigned NUM_SRC              = 4,
    parameter int unsigned SRC_IDX_W            = $clog2(NUM_SRC),
    parameter int unsigned ADDR_WIDTH           = 16,
    parameter int unsigned HASH_ISSUE_WIDTH     = 4,
    parameter int unsigned META_MATCH_LEN_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    hash_batch_bus_arbiter_if.slave bus
);
    localparam int unsigned HIST_ADDR_W = HASH_ISSUE_WIDTH * ADDR_WIDTH;
    localparam int unsigned MML_W       = HASH_ISSUE_WIDTH * META_MATCH_LEN_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]       head_addr;
        logic [HASH_ISSUE_WIDTH-1:0] history_valid;
        logic [HIST_ADDR_W-1:0]      history_addr;
        logic [MML_W-1:0]            meta_match_len;
        logic [HASH_ISSUE_WIDTH-1:0] meta_match_can_ext;
        logic                        delim;
    } beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [SRC_IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [SRC_IDX_W-1:0] owner, owner_nxt;

    beat_t                in_beat [NUM_SRC];
    beat_t                fifo_mem [2];
    beat_t                sel_beat;
    beat_t                head;
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           cnt;

    logic                 space, push, pop, found;
    logic [SRC_IDX_W-1:0] winner, sel, sel_inc;
    logic [NUM_SRC-1:0]   ready;
    int unsigned          idx;

    // Re-pack each source's flattened slices into one beat
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign in_beat[k] = {
            bus.i_head_addr[k*ADDR_WIDTH +: ADDR_WIDTH],
            bus.i_history_valid[k*HASH_ISSUE_WIDTH +: HASH_ISSUE_WIDTH],
            bus.i_history_addr[k*HIST_ADDR_W +: HIST_ADDR_W],
            bus.i_meta_match_len[k*MML_W +: MML_W],
            bus.i_meta_match_can_ext[k*HASH_ISSUE_WIDTH +: HASH_ISSUE_WIDTH],
            bus.i_delim[k]
        };
    end

    // Space comes from registered cnt only, so i_ready never sees o_ready
    assign space = (cnt != 2'd2);
    assign pop   = (cnt != 2'd0) && bus.o_ready;

    // Round-robin winner: first valid source at or after rr_ptr
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!found && bus.i_valid[SRC_IDX_W'(idx)]) begin
                found  = 1'b1;
                winner = SRC_IDX_W'(idx);
            end
        end
    end

    // Grant mux: owner while locked, otherwise the round-robin winner
    always_comb begin
        sel   = (state == LOCKED) ? owner : winner;
        ready = '0;
        if (!rst && space && ((state == LOCKED) || found)) begin
            ready[sel] = 1'b1;
        end
    end

    assign bus.i_ready = ready;
    assign push        = |(bus.i_valid & ready);
    assign sel_beat    = in_beat[sel];
    assign sel_inc     = (sel == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    // FSM next state; owner also serves as the reported grant index
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        case (state)
            IDLE: begin
                if (push) begin
                    owner_nxt = sel;
                    if (sel_beat.delim) begin
                        rr_ptr_nxt = sel_inc;
                    end else begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (push && sel_beat.delim) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = sel_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // 2-entry output FIFO; entries cleared on reset so the bus head reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sel_beat;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = fifo_mem[rd_ptr];

    assign bus.o_valid              = (cnt != 2'd0);
    assign bus.o_head_addr          = head.head_addr;
    assign bus.o_history_valid      = head.history_valid;
    assign bus.o_history_addr       = head.history_addr;
    assign bus.o_meta_match_len     = head.meta_match_len;
    assign bus.o_meta_match_can_ext = head.meta_match_can_ext;
    assign bus.o_delim              = head.delim;
    assign bus.o_locked             = (state == LOCKED);
    assign bus.o_grant_idx          = owner;

endmodule

// File: tb/tb_hash_batch_bus_arbiter.sv
// Testbench for hash_batch_bus_arbiter.
// Random source traffic and random bus-head backpressure, checked each cycle
// against a queue-based reference model of packet-granular round-robin
// arbitration feeding a 2-deep output buffer. Includes mid-traffic resets.
module tb_hash_batch_bus_arbiter;
    localparam int unsigned NUM_SRC   = 4;
    localparam int unsigned SRC_IDX_W = 2;
    localparam int unsigned AW        = 16;
    localparam int unsigned HW        = 4;
    localparam int unsigned MW        = 5;
    localparam int unsigned NCYC      = 4000;

    typedef struct packed {
        logic [AW-1:0]    head_addr;
        logic [HW-1:0]    history_valid;
        logic [HW*AW-1:0] history_addr;
        logic [HW*MW-1:0] meta_match_len;
        logic [HW-1:0]    meta_match_can_ext;
        logic             delim;
    } beat_t;

    localparam int unsigned BW = $bits(beat_t);

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    hash_batch_bus_arbiter_if #(
        .NUM_SRC(NUM_SRC), .SRC_IDX_W(SRC_IDX_W), .ADDR_WIDTH(AW),
        .HASH_ISSUE_WIDTH(HW), .META_MATCH_LEN_WIDTH(MW)
    ) bus ();

    hash_batch_bus_arbiter #(
        .NUM_SRC(NUM_SRC), .SRC_IDX_W(SRC_IDX_W), .ADDR_WIDTH(AW),
        .HASH_ISSUE_WIDTH(HW), .META_MATCH_LEN_WIDTH(MW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit    m_locked;
    int    m_owner;
    int    m_rr;
    int    m_grant;
    beat_t m_q[$];

    // Source generators: a pending beat is held valid until accepted
    bit    pend [NUM_SRC];
    beat_t pend_beat [NUM_SRC];

    int vprob_tab [4] = '{90, 50, 90, 30};
    int rprob_tab [4] = '{100, 50, 20, 80};

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t rand_beat();
        logic [127:0] r;
        beat_t        b;
        r       = {$urandom(), $urandom(), $urandom(), $urandom()};
        b       = beat_t'(r[BW-1:0]);
        b.delim = ($urandom_range(0, 2) == 0);
        return b;
    endfunction

    function automatic beat_t obs_beat();
        beat_t b;
        b.head_addr          = bus.o_head_addr;
        b.history_valid      = bus.o_history_valid;
        b.history_addr       = bus.o_history_addr;
        b.meta_match_len     = bus.o_meta_match_len;
        b.meta_match_can_ext = bus.o_meta_match_can_ext;
        b.delim              = bus.o_delim;
        return b;
    endfunction

    // Which source the arbiter must offer ready to this cycle
    function automatic logic [NUM_SRC-1:0] model_ready();
        logic [NUM_SRC-1:0] r;
        r = '0;
        if (m_q.size() < 2) begin
            if (m_locked) begin
                r = NUM_SRC'(1) << m_owner;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    int k;
                    k = (m_rr + i) % NUM_SRC;
                    if (pend[k]) begin
                        r = NUM_SRC'(1) << k;
                        break;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < NUM_SRC; k++) begin
            bus.i_valid[k]                            = pend[k];
            bus.i_head_addr[k*AW +: AW]               = pend_beat[k].head_addr;
            bus.i_history_valid[k*HW +: HW]           = pend_beat[k].history_valid;
            bus.i_history_addr[k*HW*AW +: HW*AW]      = pend_beat[k].history_addr;
            bus.i_meta_match_len[k*HW*MW +: HW*MW]    = pend_beat[k].meta_match_len;
            bus.i_meta_match_can_ext[k*HW +: HW]      = pend_beat[k].meta_match_can_ext;
            bus.i_delim[k]                            = pend_beat[k].delim;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_o_valid"},  128'(bus.o_valid), 128'(0));
        check_eq({tag, "_i_ready"},  128'(bus.i_ready), 128'(0));
        check_eq({tag, "_o_locked"}, 128'(bus.o_locked), 128'(0));
        check_eq({tag, "_grant"},    128'(bus.o_grant_idx), 128'(0));
        check_eq({tag, "_payload"},  128'(obs_beat()), 128'(0));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        m_grant  = 0;
    endtask

    // Asynchronous reset asserted between edges; released just after a posedge
    task automatic pulse_reset();
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [NUM_SRC-1:0] exp_ready;
        logic [NUM_SRC-1:0] acc;
        bit                 armed;
        int                 armed_wait;
        int                 ph;

        for (int k = 0; k < NUM_SRC; k++) begin
            pend[k]      = 1'b0;
            pend_beat[k] = '0;
        end
        bus.o_ready = 1'b0;
        drive_inputs();
        model_reset();
        armed      = 1'b0;
        armed_wait = 0;

        #1 rst = 1'b1;
        #1;
        check_reset_outputs("init");
        @(posedge clk);
        #2 rst = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            ph = (cyc / 500) % 4;
            if (cyc == 1500 || cyc == 3000) begin
                armed = 1'b1;
            end
            if (armed && ((m_q.size() == 2 && m_locked) || armed_wait > 300)) begin
                pulse_reset();
                armed      = 1'b0;
                armed_wait = 0;
            end else if (armed) begin
                armed_wait++;
            end

            @(negedge clk);
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!pend[k] && $urandom_range(0, 99) < vprob_tab[ph]) begin
                    pend[k]      = 1'b1;
                    pend_beat[k] = rand_beat();
                end
            end
            bus.o_ready = ($urandom_range(0, 99) < rprob_tab[ph]);
            drive_inputs();
            #1;

            exp_ready = model_ready();
            check_eq("i_ready", 128'(bus.i_ready), 128'(exp_ready));
            check_eq("o_valid", 128'(bus.o_valid), 128'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check_eq("payload", 128'(obs_beat()), 128'(m_q[0]));
            end
            check_eq("o_locked", 128'(bus.o_locked), 128'(m_locked));
            check_eq("grant_idx", 128'(bus.o_grant_idx), 128'(m_grant));

            // Advance the model across the coming rising edge
            if (m_q.size() != 0 && bus.o_ready) begin
                void'(m_q.pop_front());
            end
            for (int k = 0; k < NUM_SRC; k++) begin
                acc[k] = pend[k] && exp_ready[k];
            end
            for (int k = 0; k < NUM_SRC; k++) begin
                if (acc[k]) begin
                    m_q.push_back(pend_beat[k]);
                    m_grant = k;
                    if (pend_beat[k].delim) begin
                        m_locked = 1'b0;
                        m_rr     = (k + 1) % NUM_SRC;
                    end else begin
                        m_locked = 1'b1;
                        m_owner  = k;
                    end
                    pend[k] = 1'b0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
